stepper_tone_gen: RTL and testbench

// Downstream of the MIDI pitch converter. Consumes its 24-bit half-period count: 50 MHz clock cycles per half

---
 rtl/stepper_tone_gen_pkg.sv | 11 +
 rtl/stepper_oct_scale.sv | 31 +++
 rtl/stepper_tone_gen.sv | 143 ++++++++++++++
 tb/tb_stepper_tone_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/stepper_tone_gen_pkg.sv
// Shared types and constants for the stepper tone generator.
package stepper_tone_gen_pkg;
  localparam int CNT_W_DEF = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_HOLD} state_t;

  localparam logic [1:0] OCT_SAME  = 2'd0;
  localparam logic [1:0] OCT_UP1   = 2'd1;
  localparam logic [1:0] OCT_DOWN1 = 2'd2;
  localparam logic [1:0] OCT_UP2   = 2'd3;
endpackage

// File: rtl/stepper_oct_scale.sv
// Octave scaling of the half-period count with saturation and a minimum clamp.
module stepper_oct_scale
  import stepper_tone_gen_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int MIN_HALF = 2
) (
  input  logic [CNT_W-1:0] half,
  input  logic [1:0]       oct,
  output logic [CNT_W-1:0] p_eff
);
  localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(MIN_HALF);

  logic [CNT_W-1:0] scaled;

  always_comb begin
    scaled = half;
    case (oct)
      OCT_UP1:   scaled = half >> 1;
      OCT_DOWN1: scaled = half[CNT_W-1] ? '1 : (half << 1);
      OCT_UP2:   scaled = half >> 2;
      default:   scaled = half;
    endcase
    // zero input stays zero so "no note" survives scaling; shifted-out values clamp up
    p_eff = scaled;
    if (half == '0)
      p_eff = '0;
    else if (scaled < MIN_LIM)
      p_eff = MIN_LIM;
  end
endmodule

// File: rtl/stepper_tone_gen.sv
// Square-wave STEP/DIR/ENABLE generator for one stepper channel driven by a half-period count.
module stepper_tone_gen
  import stepper_tone_gen_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int MIN_HALF    = 2,
  parameter int DIR_STEPS   = 200,
  parameter int IDLE_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] halfPeriodIn,
  input  logic             noteOn,
  input  logic [1:0]       octSel,
  output logic             stepOut,
  output logic             dirOut,
  output logic             enableOut,
  output logic             busy
);
  localparam int TW = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int SW = (DIR_STEPS > 1) ? $clog2(DIR_STEPS) : 1;
  localparam logic [TW-1:0] TMR_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [SW-1:0] STP_LAST = SW'(DIR_STEPS - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] p_eff, p_lat, p_lat_n, phase, phase_n;
  logic [TW-1:0]    tmr, tmr_n;
  logic [SW-1:0]    scnt;
  logic             dir_pend, step_n, go, half_end, rise, fall;

  stepper_oct_scale #(.CNT_W(CNT_W), .MIN_HALF(MIN_HALF)) u_scale (
    .half  (halfPeriodIn),
    .oct   (octSel),
    .p_eff (p_eff)
  );

  assign go       = noteOn && (p_eff != '0);
  assign half_end = (phase == p_lat - CNT_W'(1));

  always_comb begin
    state_n = state;
    phase_n = phase;
    p_lat_n = p_lat;
    step_n  = stepOut;
    tmr_n   = tmr;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_n = ST_RUN;
          p_lat_n = p_eff;
          phase_n = '0;
        end
      end
      ST_RUN: begin
        if (!go && !stepOut) begin
          state_n = ST_HOLD;
          phase_n = '0;
          tmr_n   = '0;
        end else if (half_end) begin
          step_n  = ~stepOut;
          phase_n = '0;
          if (go) p_lat_n = p_eff;
          else begin
            state_n = ST_HOLD;
            tmr_n   = '0;
          end
        end else begin
          phase_n = phase + CNT_W'(1);
          if (!go) state_n = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // the high half finishes on the latched period; go only matters at its end
        if (half_end) begin
          step_n  = 1'b0;
          phase_n = '0;
          if (go) begin
            state_n = ST_RUN;
            p_lat_n = p_eff;
          end else begin
            state_n = ST_HOLD;
            tmr_n   = '0;
          end
        end else begin
          phase_n = phase + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (go) begin
          state_n = ST_RUN;
          p_lat_n = p_eff;
          phase_n = '0;
          tmr_n   = '0;
        end else if (tmr == TMR_LAST) begin
          state_n = ST_IDLE;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + TW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign rise = !stepOut && step_n;
  assign fall = stepOut && !step_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      phase     <= '0;
      p_lat     <= '0;
      tmr       <= '0;
      stepOut   <= 1'b0;
      enableOut <= 1'b0;
      busy      <= 1'b0;
      scnt      <= '0;
      dir_pend  <= 1'b0;
      dirOut    <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      p_lat     <= p_lat_n;
      tmr       <= tmr_n;
      stepOut   <= step_n;
      enableOut <= (state_n != ST_IDLE);
      busy      <= (state_n == ST_RUN) || (state_n == ST_DRAIN);
      if (rise) begin
        if (scnt == STP_LAST) begin
          scnt     <= '0;
          dir_pend <= 1'b1;
        end else begin
          scnt <= scnt + SW'(1);
        end
      end
      // direction flips only as STEP goes low so the driver never sees DIR move mid-pulse
      if (fall && dir_pend) begin
        dirOut   <= ~dirOut;
        dir_pend <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_stepper_tone_gen.sv
// Scoreboarded bench: expectations are queued as (cycle, signal, value) when stimulus is driven.
module tb_stepper_tone_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] halfPeriodIn = '0;
  logic        noteOn = 1'b0;
  logic [1:0]  octSel = 2'd0;
  logic        stepOut, dirOut, enableOut, busy;

  logic [23:0] sc_h = '0;
  logic [1:0]  sc_o = '0;
  logic [23:0] sc_p;

  always #5 clk = ~clk;

  stepper_tone_gen #(.CNT_W(24), .MIN_HALF(2), .DIR_STEPS(4), .IDLE_CYCLES(100)) dut (
    .clk          (clk),
    .rst          (rst),
    .halfPeriodIn (halfPeriodIn),
    .noteOn       (noteOn),
    .octSel       (octSel),
    .stepOut      (stepOut),
    .dirOut       (dirOut),
    .enableOut    (enableOut),
    .busy         (busy)
  );

  stepper_oct_scale #(.CNT_W(24), .MIN_HALF(2)) u_sc (
    .half  (sc_h),
    .oct   (sc_o),
    .p_eff (sc_p)
  );

  typedef struct {
    int    cyc;
    int    sig;
    logic  val;
    string tag;
  } sb_t;

  sb_t   q[$];
  int    nvec = 0;
  int    nerr = 0;
  int    cyc = 0;
  int    base = 0;
  string names[4] = '{"step", "en", "dir", "busy"};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic logic obs(input int sig);
    case (sig)
      0: return stepOut;
      1: return enableOut;
      2: return dirOut;
      default: return busy;
    endcase
  endfunction

  task automatic sb_push(input int n, input int sig, input logic v);
    q.push_back('{base + n, sig, v, $sformatf("%s@%0d", names[sig], n)});
  endtask

  // monitor: one cycle count per posedge, outputs sampled 1 time unit later
  initial begin
    logic prev_dir;
    sb_t  e;
    prev_dir = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      while (q.size() != 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) chk({e.tag, "_late"}, cyc, e.cyc);
        else chk(e.tag, {31'd0, obs(e.sig)}, {31'd0, e.val});
      end
      if (dirOut !== prev_dir) chk("dir_change_step_low", {31'd0, stepOut}, 32'd0);
      prev_dir = dirOut;
    end
  end

  task automatic set_base();
    base = cyc + 1;
  endtask

  task automatic wait_to(input int n);
    int g = 0;
    while (cyc < base + n - 1 && g < 100000) begin
      @(negedge clk);
      g++;
    end
  endtask

  task automatic drain_q();
    int g = 0;
    while (q.size() != 0 && g < 2000) begin
      @(negedge clk);
      g++;
    end
    chk("sb_drain", q.size(), 32'd0);
    q.delete();
  endtask

  task automatic do_reset();
    noteOn = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_step", {31'd0, stepOut}, 32'd0);
    chk("rst_en", {31'd0, enableOut}, 32'd0);
    chk("rst_dir", {31'd0, dirOut}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
  endtask

  logic [23:0] vh[8] = '{24'h900000, 24'd5, 24'd0, 24'd1, 24'd5, 24'd100, 24'h7FFFFF, 24'h123456};
  logic [1:0]  vo[8] = '{2'd2, 2'd3, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd0};
  logic [23:0] vp[8] = '{24'hFFFFFF, 24'd2, 24'd0, 24'd2, 24'd10, 24'd50, 24'hFFFFFE, 24'h123456};

  initial begin
    @(negedge clk);

    // idle with a valid count but no gate, then reset mid-run
    do_reset();
    halfPeriodIn = 24'd10; octSel = 2'd0; set_base();
    for (int s = 0; s < 4; s++) sb_push(0, s, 1'b0);
    sb_push(6, 1, 1'b0); sb_push(6, 3, 1'b0);
    wait_to(8);
    noteOn = 1'b1; set_base();
    sb_push(0, 1, 1'b1); sb_push(12, 0, 1'b1);
    sb_push(13, 0, 1'b0); sb_push(13, 1, 1'b0); sb_push(13, 3, 1'b0);
    wait_to(13); rst = 1'b1;
    @(negedge clk); rst = 1'b0; noteOn = 1'b0;
    drain_q();

    // basic tone at P=10
    do_reset();
    halfPeriodIn = 24'd10; noteOn = 1'b1; set_base();
    sb_push(0, 0, 1'b0); sb_push(0, 1, 1'b1); sb_push(0, 3, 1'b1);
    sb_push(9, 0, 1'b0); sb_push(10, 0, 1'b1); sb_push(19, 0, 1'b1);
    sb_push(20, 0, 1'b0); sb_push(29, 0, 1'b0); sb_push(30, 0, 1'b1);
    drain_q();

    // retune mid half-period
    do_reset();
    halfPeriodIn = 24'd10; noteOn = 1'b1; set_base();
    sb_push(10, 0, 1'b1); sb_push(19, 0, 1'b1); sb_push(20, 0, 1'b0);
    sb_push(39, 0, 1'b0); sb_push(40, 0, 1'b1);
    wait_to(16); halfPeriodIn = 24'd20;
    drain_q();

    // note-off inside a high half: drain, hold, enable timeout
    do_reset();
    halfPeriodIn = 24'd10; noteOn = 1'b1; set_base();
    sb_push(15, 0, 1'b1); sb_push(15, 3, 1'b1); sb_push(19, 0, 1'b1);
    sb_push(20, 0, 1'b0); sb_push(20, 1, 1'b1); sb_push(20, 3, 1'b0);
    sb_push(119, 1, 1'b1); sb_push(120, 1, 1'b0);
    wait_to(13); noteOn = 1'b0;
    drain_q();

    // re-assert during hold: no enable gap
    do_reset();
    halfPeriodIn = 24'd10; noteOn = 1'b1; set_base();
    sb_push(20, 0, 1'b0); sb_push(69, 1, 1'b1); sb_push(70, 1, 1'b1);
    sb_push(70, 3, 1'b1); sb_push(79, 0, 1'b0); sb_push(80, 0, 1'b1);
    sb_push(125, 1, 1'b1);
    wait_to(13); noteOn = 1'b0;
    wait_to(70); noteOn = 1'b1;
    drain_q();

    // re-assert while draining: back to run at the boundary
    do_reset();
    halfPeriodIn = 24'd10; noteOn = 1'b1; set_base();
    sb_push(20, 0, 1'b0); sb_push(20, 3, 1'b1); sb_push(29, 0, 1'b0); sb_push(30, 0, 1'b1);
    wait_to(13); noteOn = 1'b0;
    wait_to(16); noteOn = 1'b1;
    drain_q();

    // direction reversal every 4 rises
    do_reset();
    halfPeriodIn = 24'd10; noteOn = 1'b1; set_base();
    sb_push(70, 2, 1'b0); sb_push(79, 2, 1'b0); sb_push(80, 0, 1'b0);
    sb_push(80, 2, 1'b1); sb_push(159, 2, 1'b1); sb_push(160, 2, 1'b0);
    drain_q();

    // two octaves up on 5 clamps to the minimum half-period
    do_reset();
    halfPeriodIn = 24'd5; octSel = 2'd3; noteOn = 1'b1; set_base();
    sb_push(1, 0, 1'b0); sb_push(2, 0, 1'b1); sb_push(3, 0, 1'b1); sb_push(4, 0, 1'b0);
    drain_q();

    // unmapped note never starts
    do_reset();
    halfPeriodIn = 24'd0; octSel = 2'd0; noteOn = 1'b1; set_base();
    sb_push(0, 1, 1'b0); sb_push(0, 3, 1'b0); sb_push(5, 0, 1'b0); sb_push(5, 1, 1'b0);
    drain_q();

    // scaler vectors
    for (int i = 0; i < 8; i++) begin
      sc_h = vh[i]; sc_o = vo[i];
      #1;
      chk($sformatf("scale%0d", i), {8'd0, sc_p}, {8'd0, vp[i]});
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
